rv_cache_bus: RTL

RV_CACHE_BUS -- requirements
Module: rv_cache_bus

---
 rtl/rv_cache_bus_if.sv | 35 +++
 rtl/rv_cache_bus.sv | 108 ++++++++++
 2 files changed

// File: rtl/rv_cache_bus_if.sv
// Cache-side request/response and external bus signals for rv_cache_bus.
// slave is the bridge's view; master is the requester/bus-model view.
interface rv_cache_bus_if;
   logic [31:0] i_addr;
   logic        i_read;
   logic        i_write;
   logic [31:0] i_write_data;
   logic [3:0]  i_write_sel;
   logic        i_miss;
   logic [31:0] o_data;
   logic        o_ack;
   logic        o_busy;
   logic [31:0] o_bus_addr;
   logic        o_bus_req;
   logic        o_bus_we;
   logic [3:0]  o_bus_sel;
   logic [31:0] o_bus_wdata;
   logic [31:0] i_bus_rdata;
   logic        i_bus_ack;
   logic        o_error;

   modport slave (
      input  i_addr, i_read, i_write, i_write_data, i_write_sel, i_miss,
      input  i_bus_rdata, i_bus_ack,
      output o_data, o_ack, o_busy, o_bus_addr, o_bus_req, o_bus_we,
      output o_bus_sel, o_bus_wdata, o_error
   );

   modport master (
      output i_addr, i_read, i_write, i_write_data, i_write_sel, i_miss,
      output i_bus_rdata, i_bus_ack,
      input  o_data, o_ack, o_busy, o_bus_addr, o_bus_req, o_bus_we,
      input  o_bus_sel, o_bus_wdata, o_error
   );
endinterface

// File: rtl/rv_cache_bus.sv
// Single-transaction bridge from a cache miss/write-through port to a req/ack bus.
// Optional bus timeout abort enabled by defining RV_BUS_TIMEOUT_EN.
module rv_cache_bus #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic           i_clk,
   input  logic           i_reset,
   rv_cache_bus_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("rv_cache_bus: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]  state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] data_q;
   logic [3:0]  sel_q;
   logic        we_q;
   logic        start;
   logic        timeout;

   assign start = (state == ST_IDLE) && bus.i_miss && (bus.i_read || bus.i_write);

`ifdef RV_BUS_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             err_q;

   // cnt equals the number of REQ cycles already elapsed; the last allowed
   // REQ cycle is TO_LAST, so o_bus_req stays high exactly TIMEOUT_CYCLES cycles.
   assign timeout = (state == ST_REQ) && !bus.i_bus_ack && (cnt == TO_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         if (start)
            cnt <= '0;
         else if (state == ST_REQ)
            cnt <= cnt + 1'b1;
         err_q <= timeout;
      end
   end

   assign bus.o_error = err_q;
`else
   assign timeout     = 1'b0;
   assign bus.o_error = 1'b0;
`endif

   // An ack in the final counted cycle wins over the timeout.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr_q  <= bus.i_addr;
                  we_q    <= bus.i_write;
                  sel_q   <= bus.i_write ? bus.i_write_sel : 4'hF;
                  wdata_q <= bus.i_write_data;
                  state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (bus.i_bus_ack) begin
                  data_q <= we_q ? 32'h0 : bus.i_bus_rdata;
                  state  <= ST_DONE;
               end else if (timeout) begin
                  data_q <= 32'hFFFF_FFFF;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_bus_req   = (state == ST_REQ);
   assign bus.o_ack       = (state == ST_DONE);
   assign bus.o_busy      = (state != ST_IDLE);
   assign bus.o_bus_addr  = addr_q;
   assign bus.o_bus_we    = we_q;
   assign bus.o_bus_sel   = sel_q;
   assign bus.o_bus_wdata = wdata_q;
   assign bus.o_data      = data_q;

endmodule
